// File: rtl/alarma_secuenciador_if.sv
// Request/actuator bundle between the alarm logic, the sequencer and the actuators.
// The master drives the enable, tick and raw requests; the slave (the sequencer) drives the actuators.
interface alarma_secuenciador_if;
    logic       en;
    logic       tick;
    logic       req_avis;
    logic       req_ala;
    logic       req_vent;
    logic       ack;
    logic       avis_out;
    logic       ala_out;
    logic       vent_out;
    logic [1:0] estado;

    modport master (
        output en, tick, req_avis, req_ala, req_vent, ack,
        input  avis_out, ala_out, vent_out, estado
    );

    modport slave (
        input  en, tick, req_avis, req_ala, req_vent, ack,
        output avis_out, ala_out, vent_out, estado
    );
endinterface

// File: rtl/alarma_secuenciador.sv
// Escalation sequencer for the child-in-vehicle monitor: debounces the raw requests on the
// slow tick, runs the notice/alarm/silence state machine and holds ventilation for a minimum time.
module alarma_secuenciador #(
    parameter int DEB_TICKS = 3,
    parameter int ESC_TICKS = 10,
    parameter int SIL_TICKS = 30,
    parameter int VENT_MIN  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alarma_secuenciador_if.slave  bus
);
    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        AVISO    = 2'd1,
        ALARMA   = 2'd2,
        SILENCIO = 2'd3
    } estado_t;

    localparam logic [7:0] DEB_MAX   = 8'(DEB_TICKS);
    localparam logic [7:0] ESC_LAST  = 8'(ESC_TICKS - 1);
    localparam logic [7:0] SIL_LAST  = 8'(SIL_TICKS - 1);
    localparam logic [7:0] VENT_LOAD = 8'(VENT_MIN);

    logic       clear;
    logic [2:0] req_vec;
    logic [2:0] q_vec;
    logic       q_avis;
    logic       q_ala;
    logic       q_vent;

    assign clear   = !rst_n || !bus.en;
    assign req_vec = {bus.req_vent, bus.req_ala, bus.req_avis};
    assign q_avis  = q_vec[0];
    assign q_ala   = q_vec[1];
    assign q_vent  = q_vec[2];

    // One saturating tick counter plus qualified flag per raw request.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_qual
            logic [7:0] cnt_q;
            logic [7:0] cnt_d;
            logic       q_q;
            logic       q_d;

            always_comb begin
                cnt_d = cnt_q;
                q_d   = q_q;
                if (!req_vec[gi]) begin
                    cnt_d = '0;
                    q_d   = 1'b0;
                end else if (bus.tick) begin
                    if (cnt_q != DEB_MAX) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (cnt_d == DEB_MAX) begin
                        q_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (clear) begin
                    cnt_q <= '0;
                    q_q   <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    q_q   <= q_d;
                end
            end

            assign q_vec[gi] = q_q;
        end
    endgenerate

    estado_t    state_q;
    logic [7:0] tcnt_q;
    logic       avis_q;
    logic       ala_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= REPOSO;
            tcnt_q  <= '0;
            avis_q  <= 1'b0;
            ala_q   <= 1'b0;
        end else begin
            case (state_q)
                REPOSO: begin
                    if (q_ala) begin
                        state_q <= ALARMA;
                        avis_q  <= 1'b1;
                        ala_q   <= 1'b1;
                    end else if (q_avis) begin
                        state_q <= AVISO;
                        tcnt_q  <= '0;
                        avis_q  <= 1'b1;
                    end
                end
                AVISO: begin
                    if (q_ala) begin
                        state_q <= ALARMA;
                        ala_q   <= 1'b1;
                    end else if (!q_avis) begin
                        state_q <= REPOSO;
                        avis_q  <= 1'b0;
                    end else if (bus.tick) begin
                        if (tcnt_q == ESC_LAST) begin
                            state_q <= ALARMA;
                            ala_q   <= 1'b1;
                        end else begin
                            tcnt_q <= tcnt_q + 8'd1;
                        end
                    end
                end
                ALARMA: begin
                    // Latched: only the operator acknowledge leaves this state.
                    if (bus.ack) begin
                        state_q <= SILENCIO;
                        tcnt_q  <= '0;
                        ala_q   <= 1'b0;
                    end else if (bus.tick) begin
                        ala_q <= ~ala_q;
                    end
                end
                SILENCIO: begin
                    if (bus.tick) begin
                        if (tcnt_q == SIL_LAST) begin
                            if (q_ala || q_avis) begin
                                state_q <= ALARMA;
                                ala_q   <= 1'b1;
                            end else begin
                                state_q <= REPOSO;
                                avis_q  <= 1'b0;
                            end
                        end else begin
                            tcnt_q <= tcnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= REPOSO;
                end
            endcase
        end
    end

    logic       q_vent_prev_q;
    logic       vent_q;
    logic [7:0] vent_cnt_q;

    // A fresh qualification (re)loads the minimum on-time; release needs both flag and timer idle.
    always_ff @(posedge clk) begin
        if (clear) begin
            q_vent_prev_q <= 1'b0;
            vent_q        <= 1'b0;
            vent_cnt_q    <= '0;
        end else begin
            q_vent_prev_q <= q_vent;
            if (q_vent && !q_vent_prev_q) begin
                vent_q     <= 1'b1;
                vent_cnt_q <= VENT_LOAD;
            end else begin
                if (!q_vent && vent_cnt_q == 8'd0) begin
                    vent_q <= 1'b0;
                end
                if (bus.tick && vent_cnt_q != 8'd0) begin
                    vent_cnt_q <= vent_cnt_q - 8'd1;
                end
            end
        end
    end

    assign bus.estado   = state_q;
    assign bus.avis_out = avis_q;
    assign bus.ala_out  = ala_q;
    assign bus.vent_out = vent_q;
endmodule

// File: doc/alarma_secuenciador.md
# alarma_secuenciador

Sequencing controller between the combinational alarm/vent/notice logic and the physical actuators of the child-in-vehicle monitor. It takes the raw request levels (notice, alarm, ventilation), qualifies them against a slow time-base tick, and runs the escalation state machine that drives the actuators. The state machine escalates a notice to an alarm, blinks the alarm, accepts an operator silence, and enforces a minimum ventilation on-time.

## Interface
- DEB_TICKS, 3: consecutive ticks a raw request must stay high to qualify (1..255).
- ESC_TICKS, 10: ticks in AVISO with the notice still qualified before escalating to ALARMA (1..255).
- SIL_TICKS, 30: ticks spent in SILENCIO after an acknowledge (1..255).
- VENT_MIN, 20: minimum ticks vent_out stays on once asserted (1..255).
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  system enable; 0 forces every register to its reset value on the next edge.
- tick  input  1  time-base strobe, one clk wide; if held high, each cycle counts as one tick.
- req_avis  input  1  raw notice request (child present and door open).
- req_ala  input  1  raw alarm request (child present and temperature above 25).
- req_vent  input  1  raw ventilation request (child present and temperature above 28).
- ack  input  1  operator silence pulse; honoured only in ALARMA.
- avis_out  output  1  notice actuator.
- ala_out  output  1  alarm actuator (blinking).
- vent_out  output  1  ventilation actuator.
- estado  output  2  current state: 0 REPOSO, 1 AVISO, 2 ALARMA, 3 SILENCIO.

## Operation
- Priority is rst_n, then en, then normal operation. Reset/disable values are: state REPOSO, every counter 0, every qualifier flag 0, and every output 0.
- **Qualifiers:** there is one 8-bit counter and one flag per request (q_avis, q_ala, q_vent).
  - Raw request low: counter and flag both clear on the next edge.
  - Raw request high with tick: the counter increments, saturating at DEB_TICKS.
  - The flag sets on the edge where the counter reaches DEB_TICKS.
- **REPOSO:** all outputs are 0.
  - q_ala goes to ALARMA.
  - Otherwise, q_avis goes to AVISO.
  - If both are qualified on the same edge, ALARMA wins.
- **AVISO:** avis_out is 1. The escalation counter clears on entry and counts ticks.
  - q_ala goes to ALARMA.
  - Otherwise, q_avis dropping goes to REPOSO.
  - Otherwise, the edge that counts the ESC_TICKS-th tick goes to ALARMA.
- **ALARMA:** avis_out is 1. ala_out is 1 on entry and toggles on every tick.
  - The alarm is latched: clearing the requests does not exit.
  - ack goes to SILENCIO.
- **SILENCIO:** avis_out is 1 and ala_out is 0. The counter clears on entry and counts ticks.
  - ack is ignored.
  - On the SIL_TICKS-th tick: if q_ala or q_avis is set, go to ALARMA; otherwise go to REPOSO.
- **Ventilation:** independent of the FSM.
  - q_vent rising sets vent_out and loads the 8-bit min-on counter with VENT_MIN.
  - The counter decrements on each tick down to 0.
  - vent_out clears when q_vent is 0 and the counter is 0.
  - Requalification while on reloads the counter.
- All outputs and estado are registered and change on the same edge as the state.

## Timing
- Let E be the edge that samples the DEB_TICKS-th consecutive tick with the raw request high. q rises at E, and the state and outputs change at E+1.
- Raw request fall at cycle C: q clears at edge C+1, and the FSM reacts at edge C+2.
- ack is sampled at an edge while in ALARMA. At that edge estado becomes 3 and ala_out becomes 0.
- Escalation: AVISO is entered at edge A. ALARMA is entered at the edge that samples the ESC_TICKS-th tick after A.
- Blink period is 2 ticks. If a tick coincides with the entry edge into ALARMA, no toggle occurs on that edge.
- en falling mid-sequence: everything is at reset values at the next edge, including vent_out, regardless of the min-on counter.

## Test plan
- rst_n=0 with all requests high for 5 cycles -> all outputs 0 and estado=0. After release, req_ala held for 3 ticks -> estado=2 and ala_out=1 one cycle after the 3rd tick.
- req_avis high for 2 ticks, low, then high again -> no state change. Held 3 ticks -> estado=1, avis_out=1. After 10 further ticks -> estado=2.
- In ALARMA, 4 ticks -> ala_out sequence 1,0,1,0. ack -> estado=3, ala_out=0. 30 ticks with requests low -> estado=0.
- In SILENCIO with req_ala still held, after 30 ticks -> estado=2 and ala_out=1.
- req_vent qualified, then dropped after 1 tick -> vent_out stays 1 until 20 ticks after assertion, then goes 0.
- req_ala and req_avis qualify on the same edge -> direct REPOSO to ALARMA. en=0 pulse mid-ALARMA with vent on -> all outputs 0 on the next edge.
